// File: rtl/nand_phy_dq_calib.sv
`default_nettype none
// ============================================================================
// Module      : nand_phy_dq_calib
// Description : Read-capture calibration for the NAND DQ bus. Counts per-bit
//               instability near the clk0 and clk180 edges during a training
//               pattern and selects the safer re-timing edge for each bit.
//               Optional macro NAND_DQ_CALIB_OVERRIDE_EN adds a registered
//               manual override of calib_clk0_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_phy_dq_calib #(
    parameter int DQ_WIDTH      = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 16,
    parameter int CNT_W         = 5,
    parameter int ERR_THRESH    = 2
) (
    input  logic                clk0,
    input  logic                rst0,
    input  logic                calib_start,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_0,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_90,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_180,
    input  logic [DQ_WIDTH-1:0] calib_dq_rise_270,
`ifdef NAND_DQ_CALIB_OVERRIDE_EN
    input  logic                sel_override_en,
    input  logic [DQ_WIDTH-1:0] sel_override,
`endif
    output logic [DQ_WIDTH-1:0] calib_clk0_sel,
    output logic                calib_busy,
    output logic                calib_done,
    output logic [DQ_WIDTH-1:0] calib_fail
);

    // Phase counter must hold the larger of the two reload values.
    localparam int c_PC_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? (SETTLE_CYCLES - 1)
                                                              : (SAMPLE_CYCLES - 1);
    localparam int c_PC_W   = (c_PC_MAX > 0) ? $clog2(c_PC_MAX + 1) : 1;

    localparam logic [c_PC_W-1:0] c_SETTLE_LOAD = c_PC_W'(SETTLE_CYCLES - 1);
    localparam logic [c_PC_W-1:0] c_SAMPLE_LOAD = c_PC_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX     = '1;
    localparam logic [31:0]       c_THRESH      = 32'(ERR_THRESH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_PC_W-1:0]   r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [DQ_WIDTH-1:0] r_fail;
    logic [DQ_WIDTH-1:0] r_sel_cal;
    logic [CNT_W-1:0]    r_err0   [DQ_WIDTH];
    logic [CNT_W-1:0]    r_err180 [DQ_WIDTH];

    logic                w_start_acc;
    logic [DQ_WIDTH-1:0] w_inst0;
    logic [DQ_WIDTH-1:0] w_inst180;
    logic [DQ_WIDTH-1:0] w_fail_dec;
    logic [DQ_WIDTH-1:0] w_sel_dec;
    logic [DQ_WIDTH-1:0] w_sel_cal_next;

    // A start is only honoured when no calibration is in flight.
    assign w_start_acc = calib_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Per-bit instability detection and decision from the accumulated counts.
    for (genvar i = 0; i < DQ_WIDTH; i++) begin : g_bit
        assign w_inst0[i]    = (calib_dq_rise_0[i]   != calib_dq_rise_90[i]) ||
                               (calib_dq_rise_0[i]   != calib_dq_rise_270[i]);
        assign w_inst180[i]  = (calib_dq_rise_180[i] != calib_dq_rise_90[i]) ||
                               (calib_dq_rise_180[i] != calib_dq_rise_270[i]);
        assign w_fail_dec[i] = (32'(r_err0[i])   > c_THRESH) &&
                               (32'(r_err180[i]) > c_THRESH);
        // A failing bit keeps whatever edge it had; ties favour clk0.
        assign w_sel_dec[i]  = w_fail_dec[i] ? r_sel_cal[i]
                                             : (r_err0[i] <= r_err180[i]);
    end

    assign w_sel_cal_next = (r_state == S_DECIDE) ? w_sel_dec : r_sel_cal;

    // Calibration sequencer with registered status outputs.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (calib_start) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= c_SETTLE_LOAD;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SAMPLE;
                        r_cnt   <= c_SAMPLE_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DECIDE: begin
                    r_fail  <= w_fail_dec;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-bit error counters, cleared on every accepted start.
    always_ff @(posedge clk0) begin
        if (rst0 || w_start_acc) begin
            for (int i = 0; i < DQ_WIDTH; i++) begin
                r_err0[i]   <= '0;
                r_err180[i] <= '0;
            end
        end else if (r_state == S_SAMPLE) begin
            for (int i = 0; i < DQ_WIDTH; i++) begin
                if (w_inst0[i] && (r_err0[i] != c_CNT_MAX)) begin
                    r_err0[i] <= r_err0[i] + 1'b1;
                end
                if (w_inst180[i] && (r_err180[i] != c_CNT_MAX)) begin
                    r_err180[i] <= r_err180[i] + 1'b1;
                end
            end
        end
    end

    // Calibrated edge selection; only moves on the DECIDE->DONE edge.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_sel_cal <= '1;
        end else begin
            r_sel_cal <= w_sel_cal_next;
        end
    end

`ifdef NAND_DQ_CALIB_OVERRIDE_EN
    logic [DQ_WIDTH-1:0] r_sel_out;

    // Output register: manual value while overriding, calibrated value otherwise.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_sel_out <= '1;
        end else if (sel_override_en) begin
            r_sel_out <= sel_override;
        end else begin
            r_sel_out <= w_sel_cal_next;
        end
    end

    assign calib_clk0_sel = r_sel_out;
`else
    assign calib_clk0_sel = r_sel_cal;
`endif

    assign calib_busy = r_busy;
    assign calib_done = r_done;
    assign calib_fail = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_nand_phy_dq_calib.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_phy_dq_calib
// Description : Self-checking bench for nand_phy_dq_calib. Drives directed
//               training patterns into a default instance and a narrow-counter
//               instance (CNT_W=3, ERR_THRESH=7) and compares both every cycle
//               against a cycle-count-based model. Define
//               NAND_DQ_CALIB_OVERRIDE_EN to also exercise the override path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_phy_dq_calib;

    localparam int DQ     = 8;
    localparam int SETTLE = 4;
    localparam int SAMPLE = 16;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          calib_start;
    logic [DQ-1:0] r0, r90, r180, r270;
    logic          ovr_en;
    logic [DQ-1:0] ovr_val;

    logic [DQ-1:0] sel_a, fail_a, sel_b, fail_b;
    logic          busy_a, done_a, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk0 = ~clk0;

    nand_phy_dq_calib #(
        .DQ_WIDTH(DQ), .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE),
        .CNT_W(5), .ERR_THRESH(2)
    ) u_dut_a (
        .clk0(clk0), .rst0(rst0), .calib_start(calib_start),
        .calib_dq_rise_0(r0), .calib_dq_rise_90(r90),
        .calib_dq_rise_180(r180), .calib_dq_rise_270(r270),
`ifdef NAND_DQ_CALIB_OVERRIDE_EN
        .sel_override_en(ovr_en), .sel_override(ovr_val),
`endif
        .calib_clk0_sel(sel_a), .calib_busy(busy_a),
        .calib_done(done_a), .calib_fail(fail_a)
    );

    nand_phy_dq_calib #(
        .DQ_WIDTH(DQ), .SETTLE_CYCLES(SETTLE), .SAMPLE_CYCLES(SAMPLE),
        .CNT_W(3), .ERR_THRESH(7)
    ) u_dut_b (
        .clk0(clk0), .rst0(rst0), .calib_start(calib_start),
        .calib_dq_rise_0(r0), .calib_dq_rise_90(r90),
        .calib_dq_rise_180(r180), .calib_dq_rise_270(r270),
`ifdef NAND_DQ_CALIB_OVERRIDE_EN
        .sel_override_en(ovr_en), .sel_override(ovr_val),
`endif
        .calib_clk0_sel(sel_b), .calib_busy(busy_b),
        .calib_done(done_b), .calib_fail(fail_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- training pattern driver ----------------
    int   mode = 0;
    int   tick = 0;
    logic ph   = 1'b0;

    always @(posedge clk0) begin
        #1;
        ph = ~ph;
        tick++;
        r0 = '0; r90 = '0; r180 = '0; r270 = '0;
        case (mode)
            1: r0[0] = ph;
            2: begin
                r0[3] = ph; r90[3] = ~ph; r180[3] = ph; r270[3] = ~ph;
            end
            3: begin
                r0[5] = ph; r90[5] = ~ph; r180[5] = ph; r270[5] = ~ph;
            end
            4: begin
                r90[5] = ~ph; r270[5] = ~ph; r180[5] = ph;
                r0[5]  = (tick % 4 == 0) ? ph : ~ph;
            end
            5: begin
                r0[0] = ph; r90[0] = ~ph; r180[0] = ph; r270[0] = ~ph;
                r0[3] = ph; r90[3] = ~ph; r180[3] = ph; r270[3] = ~ph;
            end
            default: ;
        endcase
    end

    // ---------------- behavioural model ----------------
    // Timed purely by edge count since the accepted start edge E:
    // inputs at edges E+SETTLE+1 .. E+SETTLE+SAMPLE are scored, results and
    // done appear at edge E+SETTLE+SAMPLE+1.
    int          m_max [2] = '{31, 7};
    int          m_th  [2] = '{2, 7};
    int          c0    [2][DQ];
    int          c180  [2][DQ];
    logic [DQ-1:0] m_cal [2];
    logic [DQ-1:0] m_fail[2];
    logic [DQ-1:0] m_out [2];
    bit          m_busy, m_done, m_active, m_valid;
    int          edge_no = 0;
    int          m_start_edge;
    int          k;

    always @(posedge clk0) begin
        edge_no++;
        if (rst0) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_cal[d] = '1; m_fail[d] = '0; m_out[d] = '1;
            end
        end else begin
            if (m_active) begin
                k = edge_no - m_start_edge;
                if (k >= SETTLE + 1 && k <= SETTLE + SAMPLE) begin
                    for (int d = 0; d < 2; d++) begin
                        for (int i = 0; i < DQ; i++) begin
                            if (r0[i] != r90[i] || r0[i] != r270[i])
                                c0[d][i] = (c0[d][i] + 1 > m_max[d]) ? m_max[d] : c0[d][i] + 1;
                            if (r180[i] != r90[i] || r180[i] != r270[i])
                                c180[d][i] = (c180[d][i] + 1 > m_max[d]) ? m_max[d] : c180[d][i] + 1;
                        end
                    end
                end
                if (k == SETTLE + SAMPLE + 1) begin
                    for (int d = 0; d < 2; d++) begin
                        for (int i = 0; i < DQ; i++) begin
                            m_fail[d][i] = (c0[d][i] > m_th[d]) && (c180[d][i] > m_th[d]);
                            if (!m_fail[d][i]) m_cal[d][i] = (c0[d][i] <= c180[d][i]);
                        end
                    end
                    m_active = 1'b0;
                    m_busy   = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (calib_start) begin
                m_active     = 1'b1;
                m_start_edge = edge_no;
                m_busy       = 1'b1;
                m_done       = 1'b0;
                for (int d = 0; d < 2; d++)
                    for (int i = 0; i < DQ; i++) begin
                        c0[d][i] = 0; c180[d][i] = 0;
                    end
            end
            for (int d = 0; d < 2; d++) m_out[d] = ovr_en ? ovr_val : m_cal[d];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk0) begin
        if (m_valid) begin
            check("sel_a",  32'(sel_a),  32'(m_out[0]));
            check("fail_a", 32'(fail_a), 32'(m_fail[0]));
            check("busy_a", 32'(busy_a), 32'(m_busy));
            check("done_a", 32'(done_a), 32'(m_done));
            check("sel_b",  32'(sel_b),  32'(m_out[1]));
            check("fail_b", 32'(fail_b), 32'(m_fail[1]));
            check("busy_b", 32'(busy_b), 32'(m_busy));
            check("done_b", 32'(done_b), 32'(m_done));
        end
    end

    // Pulse start, optionally inject a stray start / reset, and report the
    // number of edges after the start edge at which done was first seen.
    task automatic run_cal(input int inj_start, input int rst_at, output int n_done);
        calib_start = 1'b1;
        @(posedge clk0); #1;
        calib_start = 1'b0;
        n_done = -1;
        for (int n = 1; n <= 40; n++) begin
            calib_start = (n == inj_start);
            rst0        = (n == rst_at);
            @(posedge clk0); #1;
            if (done_a && n_done < 0) n_done = n;
        end
        calib_start = 1'b0;
        rst0        = 1'b0;
    endtask

    int nd;

    initial begin
        rst0 = 1'b1; calib_start = 1'b0; ovr_en = 1'b0; ovr_val = '0;
        repeat (3) @(posedge clk0);
        #1;
        check("rst_sel",  32'(sel_a),  32'hFF);
        check("rst_fail", 32'(fail_a), 32'h00);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        rst0 = 1'b0;

        // bit0 clk0 sample toggles: edge near clk0 -> choose clk180
        mode = 1; repeat (2) @(posedge clk0); #1;
        run_cal(-1, -1, nd);
        check("t1_latency", 32'(nd), 32'd21);
        check("t1_sel",  32'(sel_a),  32'hFE);
        check("t1_fail", 32'(fail_a), 32'h00);
        check("t1_model_sel", 32'(m_out[0]), 32'hFE);
        check("t1_sel_b", 32'(sel_b), 32'hFE);

        // bits 0 and 3 unstable on both edges: fail, bit0 keeps its 0
        mode = 5; repeat (2) @(posedge clk0); #1;
        run_cal(-1, -1, nd);
        check("t2_fail", 32'(fail_a), 32'h09);
        check("t2_sel",  32'(sel_a),  32'hFE);

        // bit3 only: fail 0x08, bit3 keeps 1, bit0 recovers to clk0
        mode = 2; repeat (2) @(posedge clk0); #1;
        run_cal(-1, -1, nd);
        check("t3_fail", 32'(fail_a), 32'h08);
        check("t3_sel",  32'(sel_a),  32'hFF);
        check("t3_model_fail", 32'(m_fail[0]), 32'h08);

        // bit5 unstable every cycle: narrow instance saturates both at 7 -> tie
        mode = 3; repeat (2) @(posedge clk0); #1;
        run_cal(-1, -1, nd);
        check("t4_fail_b", 32'(fail_b), 32'h00);
        check("t4_sel_b",  32'(sel_b),  32'hFF);
        check("t4_fail_a", 32'(fail_a), 32'h20);

        // bit5: err0=4, err180=16 -> narrow instance 4 vs 7 saturated -> clk0
        mode = 4; repeat (2) @(posedge clk0); #1;
        run_cal(-1, -1, nd);
        check("t5_sel_b",  32'(sel_b),  32'hFF);
        check("t5_fail_b", 32'(fail_b), 32'h00);
        check("t5_fail_a", 32'(fail_a), 32'h20);

        // stray start during SAMPLE is ignored
        mode = 1; repeat (2) @(posedge clk0); #1;
        run_cal(8, -1, nd);
        check("t6_latency", 32'(nd), 32'd21);
        check("t6_sel", 32'(sel_a), 32'hFE);

        // reset mid-SAMPLE: reset outputs, done never rises
        run_cal(-1, 10, nd);
        check("t7_no_done", nd, -1);
        check("t7_sel",  32'(sel_a),  32'hFF);
        check("t7_fail", 32'(fail_a), 32'h00);
        check("t7_busy", 32'(busy_a), 32'h0);

`ifdef NAND_DQ_CALIB_OVERRIDE_EN
        mode = 1; repeat (2) @(posedge clk0); #1;
        run_cal(-1, -1, nd);
        check("ovr_pre", 32'(sel_a), 32'hFE);
        ovr_en = 1'b1; ovr_val = 8'h0F;
        check("ovr_lat", 32'(sel_a), 32'hFE);
        @(posedge clk0); #1;
        check("ovr_on", 32'(sel_a), 32'h0F);
        ovr_en = 1'b0;
        @(posedge clk0); #1;
        check("ovr_off", 32'(sel_a), 32'hFE);
        check("ovr_done", 32'(done_a), 32'h1);
`endif

        repeat (3) @(posedge clk0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
